// File: rtl/eld_count_pkg.sv
// eld_count_pkg: shared widths, defaults and FSM encoding for the ripple-counter monitor
package eld_count_pkg;
  localparam int COUNT_WIDTH = 8;
  localparam int STABLE_CYCLES_DEF = 2;
  typedef enum logic {
    WAIT_FIRST = 1'b0,
    TRACK      = 1'b1
  } state_e;
endpackage

// File: rtl/count_monitor_if.sv
// count_monitor_if: raw counter input, threshold/clear controls and monitor results
interface count_monitor_if
  import eld_count_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) ();
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] thresh;
  logic             clear;
  logic [WIDTH-1:0] count_out;
  logic             valid;
  logic             wrap_pulse;
  logic [WIDTH-1:0] wrap_cnt;
  logic             over_thresh;
  modport master (
    output q_in, thresh, clear,
    input  count_out, valid, wrap_pulse, wrap_cnt, over_thresh
  );
  modport slave (
    input  q_in, thresh, clear,
    output count_out, valid, wrap_pulse, wrap_cnt, over_thresh
  );
endinterface

// File: rtl/sync_stable.sv
// sync_stable: two-flop synchronizer followed by a run-length stability filter
module sync_stable #(
  parameter int WIDTH = 8,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] value_o,
  output logic             accept_o
);
  localparam logic [4:0] S = 5'(STABLE_CYCLES);
  logic [WIDTH-1:0] s1_q, s2_q, cand_q, cand_d;
  logic [1:0]       fill_q;
  logic [4:0]       cnt_q, cnt_d;
  // fill_q keeps the reset value of the synchronizer from counting as a sample
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      fill_q <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      fill_q <= {fill_q[0], 1'b1};
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end
  // count runs to S+1 and parks there so acceptance fires once per run
  always_comb begin
    cand_d = fill_q[1] ? s2_q : cand_q;
    cnt_d  = !fill_q[1] ? cnt_q :
             (cnt_q == '0 || s2_q != cand_q) ? 5'd1 :
             cnt_q + {4'd0, cnt_q <= S};
  end
  assign value_o  = cand_q;
  assign accept_o = cnt_q == S;
endmodule

// File: rtl/count_monitor.sv
// count_monitor: tracks a ripple counter, counting wraps and flagging threshold hits
module count_monitor
  import eld_count_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  count_monitor_if.slave bus
);
  logic [WIDTH-1:0] val, count_q, count_d, wrap_cnt_q, wrap_cnt_d;
  logic             acc, load, wrap, hit, wrap_pulse_q, over_q, over_d;
  state_e           state_q, state_d;
  sync_stable #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE_CYCLES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .d_i      (bus.q_in),
    .value_o  (val),
    .accept_o (acc)
  );
  always_ff @(posedge clk) state_q <= reset ? WAIT_FIRST : state_d;
  always_comb state_d = (state_q == WAIT_FIRST && acc) ? TRACK : state_q;
  always_comb bus.valid = state_q == TRACK;
  // clear and a same-cycle wrap or hit resolve in favour of the new event
  always_comb begin
    load       = acc && (state_q == WAIT_FIRST || val != count_q);
    wrap       = acc && state_q == TRACK && val < count_q;
    hit        = acc && val >= bus.thresh;
    count_d    = load ? val : count_q;
    wrap_cnt_d = bus.clear ? WIDTH'(wrap) : wrap_cnt_q + WIDTH'(wrap && wrap_cnt_q != '1);
    over_d     = hit || (over_q && !bus.clear);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      wrap_cnt_q   <= '0;
      wrap_pulse_q <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_pulse_q <= wrap;
      over_q       <= over_d;
    end
  end
  assign bus.count_out   = count_q;
  assign bus.wrap_cnt    = wrap_cnt_q;
  assign bus.wrap_pulse  = wrap_pulse_q;
  assign bus.over_thresh = over_q;
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: scoreboard bench with a run-length reference model of count_monitor
module tb_count_monitor;
  localparam int S = 2;
  typedef struct {
    logic [7:0] cnt;
    logic       v;
    logic       p;
    logic [7:0] wc;
    logic       o;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sbq[$];
  logic [7:0] hist[$];
  count_monitor_if #(.WIDTH(8)) bus ();
  count_monitor dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic hold(input logic [7:0] v, input int n);
    bus.q_in = v;
    tick(n);
  endtask
  // model: a value is taken at edge k when samples k-2-S..k-3 form a fresh run of S
  initial begin
    logic m_v, m_o, acc, wrap, hit;
    logic [7:0] m_cnt, m_wc, v;
    int k;
    m_v = 0; m_o = 0; m_cnt = 0; m_wc = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        hist.delete();
        m_v = 0; m_o = 0; m_cnt = 0; m_wc = 0; wrap = 0;
      end else begin
        hist.push_back(bus.q_in);
        k = hist.size() - 1;
        acc = 0; wrap = 0; hit = 0; v = 0;
        if (k - 2 - S >= 0) begin
          v = hist[k-3];
          acc = 1;
          for (int i = k - 2 - S; i <= k - 3; i++) if (hist[i] != v) acc = 0;
          if (k - 3 - S >= 0 && hist[k-3-S] == v) acc = 0;
        end
        if (acc) begin
          if (!m_v) begin
            m_v = 1;
            m_cnt = v;
          end else begin
            wrap = v < m_cnt;
            m_cnt = v;
          end
          hit = v >= bus.thresh;
        end
        m_wc = bus.clear ? {7'd0, wrap} : (wrap && m_wc != 8'hFF) ? m_wc + 8'd1 : m_wc;
        m_o = hit || (m_o && !bus.clear);
      end
      sbq.push_back('{cnt: m_cnt, v: m_v, p: wrap, wc: m_wc, o: m_o});
    end
  end
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sbq.size() == 0) chk("sb_empty", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("count_out", 32'(bus.count_out), 32'(e.cnt));
        chk("valid", 32'(bus.valid), 32'(e.v));
        chk("wrap_pulse", 32'(bus.wrap_pulse), 32'(e.p));
        chk("wrap_cnt", 32'(bus.wrap_cnt), 32'(e.wc));
        chk("over_thresh", 32'(bus.over_thresh), 32'(e.o));
      end
    end
  end
  initial begin
    logic [7:0] pool [6];
    pool = '{8'h00, 8'h20, 8'h40, 8'h80, 8'hC0, 8'hFF};
    bus.q_in = 8'h00; bus.thresh = 8'hFF; bus.clear = 1'b0;
    tick(3);
    reset = 1'b0; bus.q_in = 8'h05;
    tick(4);
    chk("first_valid_early", 32'(bus.valid), 0);
    tick(1);
    chk("first_valid", 32'(bus.valid), 1);
    chk("first_count", 32'(bus.count_out), 32'h05);
    chk("first_pulse", 32'(bus.wrap_pulse), 0);
    chk("first_wc", 32'(bus.wrap_cnt), 0);
    hold(8'hFE, 6);
    hold(8'hFF, 6);
    bus.q_in = 8'h00;
    tick(4);
    chk("wrap_pulse_early", 32'(bus.wrap_pulse), 0);
    tick(1);
    chk("wrap_count", 32'(bus.count_out), 0);
    chk("wrap_pulse", 32'(bus.wrap_pulse), 1);
    chk("wrap_wc", 32'(bus.wrap_cnt), 1);
    tick(1);
    chk("wrap_pulse_once", 32'(bus.wrap_pulse), 0);
    hold(8'h10, 6);
    hold(8'h37, 1);
    hold(8'h10, 6);
    chk("glitch_count", 32'(bus.count_out), 32'h10);
    bus.thresh = 8'h80; bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    hold(8'h7F, 6);
    chk("thr_below", 32'(bus.over_thresh), 0);
    hold(8'h80, 6);
    chk("thr_hit", 32'(bus.over_thresh), 1);
    hold(8'h20, 6);
    chk("thr_sticky", 32'(bus.over_thresh), 1);
    chk("thr_wc", 32'(bus.wrap_cnt), 1);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("clr_over", 32'(bus.over_thresh), 0);
    chk("clr_wc", 32'(bus.wrap_cnt), 0);
    chk("clr_count", 32'(bus.count_out), 32'h20);
    chk("clr_valid", 32'(bus.valid), 1);
    bus.thresh = 8'h00; bus.q_in = 8'h10;
    tick(4);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("clrwrap_wc", 32'(bus.wrap_cnt), 1);
    chk("clrhit_over", 32'(bus.over_thresh), 1);
    chk("clrwrap_pulse", 32'(bus.wrap_pulse), 1);
    tick(2);
    for (int i = 0; i < 260; i++) begin
      hold(8'h40, 3);
      hold(8'h30, 3);
    end
    chk("sat_wc", 32'(bus.wrap_cnt), 32'hFF);
    hold(8'h40, 6);
    bus.q_in = 8'h30;
    tick(5);
    chk("sat_pulse", 32'(bus.wrap_pulse), 1);
    chk("sat_wc_hold", 32'(bus.wrap_cnt), 32'hFF);
    tick(2);
    bus.q_in = 8'h44;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_count", 32'(bus.count_out), 0);
    chk("rst_wc", 32'(bus.wrap_cnt), 0);
    chk("rst_over", 32'(bus.over_thresh), 0);
    chk("rst_pulse", 32'(bus.wrap_pulse), 0);
    reset = 1'b0;
    tick(4);
    chk("rst_relatch_early", 32'(bus.valid), 0);
    tick(1);
    chk("rst_relatch_valid", 32'(bus.valid), 1);
    chk("rst_relatch_count", 32'(bus.count_out), 32'h44);
    for (int i = 0; i < 400; i++) begin
      bus.q_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) bus.thresh = 8'($urandom);
      bus.clear = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 39) == 0);
      tick(1);
      bus.clear = 1'b0;
      reset = 1'b0;
      tick(int'($urandom_range(0, 5)));
    end
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter: STABLE_CYCLES, 2, consecutive identical synchronized samples required before a value is accepted (legal 1..15).
REQ-002 Parameter: WIDTH, 8, counter value width.
REQ-003 Single clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: q_in  input  WIDTH  raw ripple-counter output, asynchronous to clk, may glitch during ripple.
REQ-007 Port: thresh  input  WIDTH  threshold for over_thresh, sampled every cycle.
REQ-008 Port: clear  input  1  synchronous clear of wrap_cnt and over_thresh.
REQ-009 Port: count_out  output  WIDTH  last accepted stable counter value.
REQ-010 Port: valid  output  1  high once the first value has been accepted.
REQ-011 Port: wrap_pulse  output  1  one-cycle pulse per detected wrap.
REQ-012 Port: wrap_cnt  output  WIDTH  number of wraps, saturating.
REQ-013 Port: over_thresh  output  1  sticky flag, accepted value >= thresh.

Function
REQ-014 q_in SHALL pass through a two-flop synchronizer before any other use.
REQ-015 A synchronized value SHALL be accepted only after it has been identical for STABLE_CYCLES consecutive cycles; any change restarts the count.
REQ-016 Latency: q_in held constant from before edge N SHALL appear on count_out after edge N+2+STABLE_CYCLES (4 cycles at default).
REQ-017 A glitch shorter than STABLE_CYCLES synchronized cycles SHALL never reach count_out.
REQ-018 FSM states: WAIT_FIRST (valid=0) and TRACK (valid=1).
REQ-019 WAIT_FIRST -> TRACK on the first acceptance; count_out loads that value; no wrap is counted on that acceptance.
REQ-020 TRACK: an accepted value equal to count_out SHALL produce no event; an accepted value that differs SHALL load count_out.
REQ-021 TRACK: an accepted value strictly less than the current count_out SHALL be a wrap; wrap_pulse is high for exactly one cycle, aligned with the count_out update.
REQ-022 wrap_cnt SHALL increment by 1 per wrap and saturate at 2^WIDTH-1 (255).
REQ-023 over_thresh SHALL set on the cycle any accepted value >= thresh; it then stays set until clear or reset; thresh=0 sets it on the first acceptance.
REQ-024 clear SHALL zero wrap_cnt and over_thresh and SHALL leave count_out, valid and FSM state unchanged.
REQ-025 Simultaneous clear and wrap: wrap_cnt SHALL become 1. Simultaneous clear and threshold hit: over_thresh SHALL become 1.
REQ-026 TRACK SHALL be left only by reset.

Reset
REQ-027 Reset SHALL clear the synchronizer, stability counter, count_out, valid, wrap_pulse, wrap_cnt and over_thresh to 0, and SHALL force WAIT_FIRST.
REQ-028 Reset asserted mid-stabilization SHALL discard the pending candidate; after release, acceptance SHALL again need the full 2+STABLE_CYCLES cycles.
REQ-029 Reset SHALL take priority over clear and all other inputs.

Structure
REQ-030 Shared package eld_count_pkg SHALL hold WIDTH, the FSM state typedef and encodings, and the STABLE_CYCLES default.
REQ-031 Sub-module sync_stable SHALL contain the two-flop synchronizer and stability filter and output (value, accept_pulse); the FSM and counters SHALL live in count_monitor.

Verification
REQ-032 Reset, then q_in=0x05 held -> valid=1 and count_out=0x05 exactly 4 cycles after first edge; wrap_pulse=0; wrap_cnt=0.
REQ-033 TRACK at 0xFE, q_in steps 0xFF then 0x00, each held 6 cycles -> count_out 0xFF then 0x00; one wrap_pulse at the 0x00 update; wrap_cnt=1.
REQ-034 count_out=0x10, q_in=0x37 for 1 cycle then back to 0x10 -> count_out stays 0x10, no wrap_pulse.
REQ-035 thresh=0x80, accepted 0x7F then 0x80 -> over_thresh rises on the 0x80 acceptance; q_in then falls to 0x20 -> over_thresh stays 1, wrap_cnt increments; clear -> over_thresh=0, wrap_cnt=0, count_out=0x20.
REQ-036 wrap_cnt=0xFF, one more wrap -> wrap_cnt stays 0xFF, wrap_pulse still pulses once.
REQ-037 Reset 2 cycles into stabilizing 0x44 -> all outputs 0, valid=0; after release with 0x44 held, count_out=0x44 exactly 4 cycles later.
